xadc_sample_sequencer: RTL and testbench

Parametrised front end between the XADC DRP/event interface and the FIR filter chain. It generates the conversion-start strobe at a programmable rate and accepts end-of-conversion events for up to four auxiliary channels. It performs the DRP read handshake with timeout, converts the 12-bit result to a left-justified signed sample tagged with its channel, and drives an offset-binary PMOD output for a selected channel. Protocol errors (overrun, DRP timeout, foreign channel) are flagged instead of silently corrupting the stream.

---
 rtl/xadc_sample_sequencer.sv | 159 +++++++++++++++
 tb/tb_xadc_sample_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_sample_sequencer.sv
// XADC sample sequencer: programmable convst generator, DRP read handshake
// with timeout, conversion to left-justified signed samples tagged with a
// logical channel, offset-binary PMOD output and sticky protocol error flags.
module xadc_sample_sequencer #(
    parameter int CLK_DIV = 1000,
    parameter int NUM_CH  = 2,
    parameter int CH_BASE = 22,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             bipolar,
    input  logic [1:0]       pmod_ch,
    input  logic             clear_err,
    output logic             convst,
    input  logic             eoc_in,
    input  logic [4:0]       channel_in,
    output logic [6:0]       daddr,
    output logic             den,
    input  logic             drdy_in,
    input  logic [15:0]      do_in,
    output logic [15:0]      sample_data,
    output logic [1:0]       sample_ch,
    output logic             sample_valid,
    output logic [OUT_W-1:0] pmod_out,
    output logic             overrun_err,
    output logic             timeout_err,
    output logic             chan_err
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    // The timer starts at 0 in the first WAIT_DRDY cycle, which is already
    // one cycle after den, so the last allowed wait cycle is TIMEOUT-2.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);
    localparam logic [4:0] BASE = 5'(CH_BASE);
    localparam logic [5:0] LIMIT = 6'(CH_BASE + NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_DRDY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_count;
    logic [TMR_W-1:0] timer;
    logic [4:0]       latched_ch;

    logic [1:0]       rel_ch;
    logic             ch_valid;
    logic [11:0]      raw;
    logic [11:0]      conv;
    logic [11:0]      offset_res;
    logic [OUT_W-1:0] pmod_next;
    logic             unused_low;

    logic             ovr_hit;
    logic             tmo_hit;
    logic             chn_hit;

    assign rel_ch   = 2'(latched_ch - BASE);
    assign ch_valid = (latched_ch >= BASE) && ({1'b0, latched_ch} < LIMIT);

    // Unipolar results are re-centred by flipping the MSB (subtract 0x800).
    assign raw        = do_in[15:4];
    assign conv       = bipolar ? raw : {~raw[11], raw[10:0]};
    assign offset_res = {~conv[11], conv[10:0]};
    assign pmod_next  = OUT_W'({offset_res, 4'b0000} >> (16 - OUT_W));
    assign unused_low = ^do_in[3:0];

    assign ovr_hit = eoc_in && (state != IDLE);
    assign tmo_hit = (state == WAIT_DRDY) && !drdy_in && (timer == TMR_LAST);
    assign chn_hit = (state == WAIT_DRDY) && drdy_in && !ch_valid;

    // Conversion-start divider: one-cycle convst each CLK_DIV enabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_count <= '0;
            convst    <= 1'b0;
        end else if (!enable) begin
            div_count <= '0;
            convst    <= 1'b0;
        end else if (div_count == DIV_LAST) begin
            div_count <= '0;
            convst    <= 1'b1;
        end else begin
            div_count <= div_count + CNT_W'(1);
            convst    <= 1'b0;
        end
    end

    // Read sequencer: eoc -> DRP read -> wait for drdy or timeout -> sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            latched_ch   <= '0;
            den          <= 1'b0;
            daddr        <= '0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            pmod_out     <= '0;
        end else begin
            den          <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (eoc_in) begin
                        latched_ch <= channel_in;
                        daddr      <= {2'b00, channel_in};
                        den        <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    timer <= '0;
                    state <= WAIT_DRDY;
                end
                WAIT_DRDY: begin
                    if (drdy_in) begin
                        state <= IDLE;
                        if (ch_valid) begin
                            sample_valid <= 1'b1;
                            sample_data  <= {conv, 4'b0000};
                            sample_ch    <= rel_ch;
                            if (rel_ch == pmod_ch) begin
                                pmod_out <= pmod_next;
                            end
                        end
                    end else if (timer == TMR_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            chan_err    <= 1'b0;
        end else begin
            overrun_err <= ovr_hit | (overrun_err & ~clear_err);
            timeout_err <= tmo_hit | (timeout_err & ~clear_err);
            chan_err    <= chn_hit | (chan_err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_xadc_sample_sequencer.sv
// Testbench for xadc_sample_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_xadc_sample_sequencer;

    localparam int CLK_DIV = 1000;
    localparam int NUM_CH  = 2;
    localparam int CH_BASE = 22;
    localparam int OUT_W   = 8;
    localparam int TIMEOUT = 63;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             bipolar;
    logic [1:0]       pmod_ch;
    logic             clear_err;
    logic             convst;
    logic             eoc_in;
    logic [4:0]       channel_in;
    logic [6:0]       daddr;
    logic             den;
    logic             drdy_in;
    logic [15:0]      do_in;
    logic [15:0]      sample_data;
    logic [1:0]       sample_ch;
    logic             sample_valid;
    logic [OUT_W-1:0] pmod_out;
    logic             overrun_err;
    logic             timeout_err;
    logic             chan_err;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 0;

    xadc_sample_sequencer #(
        .CLK_DIV(CLK_DIV),
        .NUM_CH (NUM_CH),
        .CH_BASE(CH_BASE),
        .OUT_W  (OUT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .bipolar     (bipolar),
        .pmod_ch     (pmod_ch),
        .clear_err   (clear_err),
        .convst      (convst),
        .eoc_in      (eoc_in),
        .channel_in  (channel_in),
        .daddr       (daddr),
        .den         (den),
        .drdy_in     (drdy_in),
        .do_in       (do_in),
        .sample_data (sample_data),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .pmod_out    (pmod_out),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err),
        .chan_err    (chan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs produced by the reference model.
    logic             exp_convst = 0;
    logic             exp_den = 0;
    logic [6:0]       exp_daddr = 0;
    logic [15:0]      exp_data = 0;
    logic [1:0]       exp_ch = 0;
    logic             exp_valid = 0;
    logic [OUT_W-1:0] exp_pmod = 0;
    logic             exp_ovr = 0;
    logic             exp_tmo = 0;
    logic             exp_chn = 0;

    // Model bookkeeping: cycle stamps of the outstanding read.
    int cyc = 0;
    int run_len = 0;
    int den_cyc = 0;
    int rd_ch = 0;
    int r_val = 0;
    int s_val = 0;
    bit busy = 0;
    bit m_ovr, m_tmo, m_chn;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic eoc, input logic drdy, input logic [4:0] ch,
                                 input logic [15:0] data, input logic bip,
                                 input logic [1:0] pch, input logic clr);
        eoc_in     = eoc;
        drdy_in    = drdy;
        channel_in = ch;
        do_in      = data;
        bipolar    = bip;
        pmod_ch    = pch;
        clear_err  = clr;
    endtask

    // One complete read: eoc now, drdy 'gap' cycles after den, returns at the sample cycle.
    task automatic doRead(input logic [4:0] ch, input logic [15:0] data, input logic bip, input int gap);
        channel_in = ch;
        bipolar    = bip;
        eoc_in     = 1'b1;
        tick();
        eoc_in = 1'b0;
        repeat (gap) tick();
        drdy_in = 1'b1;
        do_in   = data;
        tick();
        drdy_in = 1'b0;
    endtask

    // Reference model: convst from enabled run length, reads tracked by den cycle stamp.
    always @(posedge clk or negedge reset_n) begin
        cyc++;
        if (!reset_n) begin
            run_len = 0;
            busy = 0;
            exp_convst = 0; exp_den = 0; exp_daddr = 0; exp_data = 0; exp_ch = 0;
            exp_valid = 0; exp_pmod = 0; exp_ovr = 0; exp_tmo = 0; exp_chn = 0;
        end else begin
            m_ovr = eoc_in && busy;
            m_tmo = 0;
            m_chn = 0;
            exp_den = 0;
            exp_valid = 0;
            run_len = enable ? run_len + 1 : 0;
            exp_convst = enable && (run_len % CLK_DIV == 0);
            if (busy) begin
                if (cyc > den_cyc && drdy_in) begin
                    busy = 0;
                    r_val = int'(do_in) / 16;
                    s_val = bipolar ? r_val : (r_val + 2048) % 4096;
                    if (rd_ch >= CH_BASE && rd_ch < CH_BASE + NUM_CH) begin
                        exp_valid = 1;
                        exp_data  = 16'(s_val * 16);
                        exp_ch    = 2'(rd_ch - CH_BASE);
                        if (rd_ch - CH_BASE == int'(pmod_ch))
                            exp_pmod = OUT_W'(((s_val * 16 + 32768) % 65536) >> (16 - OUT_W));
                    end else begin
                        m_chn = 1;
                    end
                end else if (cyc == den_cyc + TIMEOUT - 1) begin
                    busy = 0;
                    m_tmo = 1;
                end
            end else if (eoc_in) begin
                busy = 1;
                den_cyc = cyc + 1;
                rd_ch = int'(channel_in);
                exp_den = 1;
                exp_daddr = {2'b00, channel_in};
            end
            exp_ovr = m_ovr || (exp_ovr && !clear_err);
            exp_tmo = m_tmo || (exp_tmo && !clear_err);
            exp_chn = m_chn || (exp_chn && !clear_err);
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("convst",       16'(convst),       16'(exp_convst));
            checkOutput("den",          16'(den),          16'(exp_den));
            checkOutput("daddr",        16'(daddr),        16'(exp_daddr));
            checkOutput("sample_valid", 16'(sample_valid), 16'(exp_valid));
            checkOutput("sample_data",  sample_data,       exp_data);
            checkOutput("sample_ch",    16'(sample_ch),    16'(exp_ch));
            checkOutput("pmod_out",     16'(pmod_out),     16'(exp_pmod));
            checkOutput("overrun_err",  16'(overrun_err),  16'(exp_ovr));
            checkOutput("timeout_err",  16'(timeout_err),  16'(exp_tmo));
            checkOutput("chan_err",     16'(chan_err),     16'(exp_chn));
        end
    end

    int pulses;
    int drdy_pct;

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
        #1 reset_n = 1'b0;
        #1 checking = 1;
        repeat (3) tick();
        checkOutput("reset_data",  sample_data,       16'h0000);
        checkOutput("reset_pmod",  16'(pmod_out),     16'h0000);
        checkOutput("reset_flags", 16'({overrun_err, timeout_err, chan_err}), 16'h0000);
        checkOutput("reset_den",   16'({den, convst, sample_valid}), 16'h0000);
        reset_n = 1'b1;
        tick();

        // Divider: pulses at 1000, 2000, 3000 cycles after enable is raised.
        enable = 1'b1;
        repeat (999) tick();
        checkOutput("convst_before_first", 16'(convst), 16'h0000);
        for (int p = 1; p <= 3; p++) begin
            tick();
            checkOutput("convst_pulse", 16'(convst), 16'h0001);
            tick();
            checkOutput("convst_width", 16'(convst), 16'h0000);
            if (p < 3) repeat (998) tick();
        end
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (convst) pulses++;
        end
        checkOutput("convst_disabled", 16'(pulses), 16'h0000);

        // Unipolar full scale and zero on channel 22 (logical 0).
        pmod_ch = 2'd0;
        doRead(5'd22, 16'hFFF0, 1'b0, 5);
        checkOutput("uni_max_valid", 16'(sample_valid), 16'h0001);
        checkOutput("uni_max_data",  sample_data,       16'h7FF0);
        checkOutput("uni_max_ch",    16'(sample_ch),    16'h0000);
        checkOutput("uni_max_pmod",  16'(pmod_out),     16'h00FF);
        tick();
        doRead(5'd22, 16'h0000, 1'b0, 2);
        checkOutput("uni_zero_data", sample_data,       16'h8000);
        checkOutput("uni_zero_pmod", 16'(pmod_out),     16'h0000);
        tick();

        // Bipolar with channel tag; logical channel 0 must not touch pmod_out.
        pmod_ch = 2'd1;
        doRead(5'd23, 16'h7FF0, 1'b1, 1);
        checkOutput("bip_max_pmod", 16'(pmod_out), 16'h00FF);
        tick();
        doRead(5'd22, 16'hFFF0, 1'b1, 3);
        checkOutput("bip_ch0_data", sample_data,    16'hFFF0);
        checkOutput("bip_ch0_pmod", 16'(pmod_out),  16'h00FF);
        tick();
        doRead(5'd23, 16'h8000, 1'b1, 2);
        checkOutput("bip_min_data", sample_data,    16'h8000);
        checkOutput("bip_min_ch",   16'(sample_ch), 16'h0001);
        checkOutput("bip_min_pmod", 16'(pmod_out),  16'h0000);
        tick();

        // Foreign channel.
        doRead(5'd16, 16'h1230, 1'b0, 2);
        checkOutput("chan_err_set",   16'(chan_err),     16'h0001);
        checkOutput("chan_err_valid", 16'(sample_valid), 16'h0000);
        tick();

        // Timeout after TIMEOUT cycles from den, then the next read works.
        channel_in = 5'd22;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        repeat (TIMEOUT - 1) tick();
        checkOutput("timeout_early", 16'(timeout_err), 16'h0000);
        tick();
        checkOutput("timeout_set", 16'(timeout_err), 16'h0001);
        doRead(5'd22, 16'h1230, 1'b1, 1);
        checkOutput("after_timeout_valid", 16'(sample_valid), 16'h0001);
        checkOutput("after_timeout_data",  sample_data,       16'h1230);
        tick();

        // Overrun: second eoc while waiting; original read still completes.
        channel_in = 5'd22;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        tick();
        channel_in = 5'd23;
        eoc_in = 1'b1;
        tick();
        eoc_in  = 1'b0;
        drdy_in = 1'b1;
        do_in   = 16'h4560;
        tick();
        drdy_in = 1'b0;
        checkOutput("overrun_set",   16'(overrun_err),  16'h0001);
        checkOutput("overrun_valid", 16'(sample_valid), 16'h0001);
        checkOutput("overrun_ch",    16'(sample_ch),    16'h0000);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checkOutput("clear_flags", 16'({overrun_err, timeout_err, chan_err}), 16'h0000);

        // Reset in the middle of a read, then a stale drdy.
        channel_in = 5'd22;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        drdy_in = 1'b1;
        do_in   = 16'hABC0;
        tick();
        drdy_in = 1'b0;
        checkOutput("stale_valid", 16'(sample_valid), 16'h0000);
        checkOutput("stale_data",  sample_data,       16'h0000);
        checkOutput("stale_pmod",  16'(pmod_out),     16'h0000);

        // Randomized traffic.
        drdy_pct = 40;
        for (int i = 0; i < 1500; i++) begin
            case ((i / 250) % 3)
                0: drdy_pct = 40;
                1: drdy_pct = 2;
                default: drdy_pct = 15;
            endcase
            applyStimulus(($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 99) < drdy_pct),
                          ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(21, 25)),
                          16'($urandom),
                          1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            reset_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
